// File: rtl/led_pwm_pkg.sv
// Shared defaults and types for the four-channel LED PWM stage.
package led_pwm_pkg;

  localparam int CHANNELS_DEF  = 4;
  localparam int DUTY_BITS_DEF = 4;
  localparam int PRESCALE_DEF  = 256;

  typedef logic [DUTY_BITS_DEF-1:0] duty_t;

endpackage

// File: rtl/led_pwm_tick.sv
// Prescaler and phase counter: one phase step every PRESCALE cycles,
// 2**DUTY_BITS-1 phases per period, cleared whenever enable is low.
module led_pwm_tick
  import led_pwm_pkg::*;
#(
  parameter int DUTY_BITS = DUTY_BITS_DEF,
  parameter int PRESCALE  = PRESCALE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  output logic                 step_o,
  output logic [DUTY_BITS-1:0] phase_o,
  output logic                 boundary_o
);

  localparam int                   PRE_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]     PRE_LAST   = PRE_W'(PRESCALE - 1);
  localparam logic [DUTY_BITS-1:0] PHASE_LAST = DUTY_BITS'((1 << DUTY_BITS) - 2);

  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [DUTY_BITS-1:0] phase_q, phase_d;
  logic                 step;
  logic                 boundary;

  assign step     = enable_i && (pre_q == PRE_LAST);
  assign boundary = step && (phase_q == PHASE_LAST);

  always_comb begin
    pre_d   = pre_q;
    phase_d = phase_q;
    if (!enable_i) begin
      pre_d   = '0;
      phase_d = '0;
    end else if (step) begin
      pre_d   = '0;
      phase_d = boundary ? '0 : phase_q + 1'b1;
    end else begin
      pre_d   = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q   <= '0;
      phase_q <= '0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
    end
  end

  assign step_o     = step;
  assign phase_o    = phase_q;
  assign boundary_o = boundary;

endmodule

// File: rtl/led_pwm.sv
// Four-channel LED PWM stage with a single pending duty slot that is
// applied only at a period boundary (or immediately while disabled).
module led_pwm
  import led_pwm_pkg::*;
#(
  parameter int CHANNELS  = CHANNELS_DEF,
  parameter int DUTY_BITS = DUTY_BITS_DEF,
  parameter int PRESCALE  = PRESCALE_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          duty_valid,
  output logic                          duty_ready,
  input  logic [CHANNELS*DUTY_BITS-1:0] duty_data,
  output logic [CHANNELS-1:0]           led,
  output logic                          period_start
);

  localparam int DW = CHANNELS * DUTY_BITS;

  logic                 step;
  logic [DUTY_BITS-1:0] phase;
  logic                 boundary;

  logic [DW-1:0]       pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic [DW-1:0]       active_q, active_d;
  logic [CHANNELS-1:0] led_q, led_d;
  logic                period_start_q;
  logic                xfer;
  logic                apply;

  led_pwm_tick #(
    .DUTY_BITS (DUTY_BITS),
    .PRESCALE  (PRESCALE)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable),
    .step_o     (step),
    .phase_o    (phase),
    .boundary_o (boundary)
  );

  // Handshake: a transfer happens on any rising edge where duty_valid and
  // duty_ready are both high; duty_data is sampled only on that edge.
  // duty_ready depends on pend_v_q alone, so it stays low from the transfer
  // until the boundary that applies it, and valid may be held high freely.
  assign duty_ready = !pend_v_q;
  assign xfer       = duty_valid && duty_ready;
  assign apply      = pend_v_q && (boundary || !enable);

  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    active_d = active_q;
    // apply and xfer never coincide: one needs a full slot, the other an empty one.
    if (apply) begin
      active_d = pend_q;
      pend_v_d = 1'b0;
    end
    if (xfer) begin
      pend_d   = duty_data;
      pend_v_d = 1'b1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
    assign led_d[g] = enable && (phase < active_q[g*DUTY_BITS +: DUTY_BITS]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q         <= '0;
      pend_v_q       <= 1'b0;
      active_q       <= '0;
      led_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pend_q         <= pend_d;
      pend_v_q       <= pend_v_d;
      active_q       <= active_d;
      led_q          <= led_d;
      period_start_q <= boundary;
    end
  end

  assign led          = led_q;
  assign period_start = period_start_q;

  logic unused_step;
  assign unused_step = step;

endmodule

// File: tb/tb_led_pwm.sv
// Self-checking bench for led_pwm with PRESCALE=4 (60-cycle period).
module tb_led_pwm;
  import led_pwm_pkg::*;

  localparam int CH  = 4;
  localparam int DB  = 4;
  localparam int PS  = 4;
  localparam int PER = ((1 << DB) - 1) * PS;

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic           duty_valid;
  logic           duty_ready;
  logic [CH*DB-1:0] duty_data;
  logic [CH-1:0]  led;
  logic           period_start;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [CH*DB-1:0] data;
    logic [31:0]      exp_cnt;  // {ch3,ch2,ch1,ch0} high cycles per period
  } vec_t;

  vec_t vecs[6];

  led_pwm #(
    .CHANNELS  (CH),
    .DUTY_BITS (DB),
    .PRESCALE  (PS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .duty_data    (duty_data),
    .led          (led),
    .period_start (period_start)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [CH*DB-1:0] data);
    duty_data  = data;
    duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
  endtask

  task automatic wait_ps(output int n, output int rdy_hi);
    n      = 0;
    rdy_hi = 0;
    while (n < 200) begin
      tick();
      n++;
      if (period_start) break;
      if (duty_ready) rdy_hi++;
    end
  endtask

  // scoreboard: one full period sampled from the cycle after period_start
  task automatic check_period(input string name, output int rdy_cnt);
    int          c[CH];
    int          ps_cnt;
    logic [31:0] cnt;
    logic [31:0] exp;
    for (int k = 0; k < CH; k++) c[k] = 0;
    ps_cnt  = 0;
    rdy_cnt = 0;
    for (int s = 0; s < PER; s++) begin
      tick();
      for (int k = 0; k < CH; k++) if (led[k]) c[k]++;
      if (period_start) ps_cnt++;
      if (duty_ready) rdy_cnt++;
    end
    cnt = {8'(c[3]), 8'(c[2]), 8'(c[1]), 8'(c[0])};
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, got %0h", name, cnt);
    end else begin
      exp = exp_q.pop_front();
      check(name, cnt, exp);
    end
    check({name, "_ps_count"}, ps_cnt, 1);
  endtask

  initial begin
    int n;
    int r;
    duty_t d0;

    vecs[0] = '{16'hF810, {8'd60, 8'd32, 8'd4,  8'd0 }};
    vecs[1] = '{16'h000F, {8'd0,  8'd0,  8'd0,  8'd60}};
    vecs[2] = '{16'h0000, {8'd0,  8'd0,  8'd0,  8'd0 }};
    vecs[3] = '{16'h1234, {8'd4,  8'd8,  8'd12, 8'd16}};
    vecs[4] = '{16'hE7A5, {8'd56, 8'd28, 8'd40, 8'd20}};
    vecs[5] = '{16'h5C39, {8'd20, 8'd48, 8'd12, 8'd36}};

    rst_n      = 1'b0;
    enable     = 1'b0;
    duty_valid = 1'b0;
    duty_data  = '0;
    repeat (3) tick();
    check("reset_led", led, 0);
    check("reset_ready", duty_ready, 1);
    check("reset_ps", period_start, 0);

    // preload while disabled
    rst_n = 1'b1;
    send(vecs[0].data);
    exp_q.push_back(vecs[0].exp_cnt);
    check("preload_ready_low", duty_ready, 0);
    tick();
    check("preload_ready_back", duty_ready, 1);
    check("preload_led_off", led, 0);

    enable = 1'b1;
    wait_ps(n, r);
    check("first_ps_latency", n, PER);
    check_period("steady_f810", r);

    // deferred updates, table-driven
    for (int i = 1; i <= 4; i++) begin
      repeat (5) tick();
      send(vecs[i].data);
      exp_q.push_back(vecs[i].exp_cnt);
      check($sformatf("vec%0d_ready_low", i), duty_ready, 0);
      wait_ps(n, r);
      check($sformatf("vec%0d_boundary_wait", i), n, PER - 6);
      check($sformatf("vec%0d_ready_before_boundary", i), r, 0);
      check($sformatf("vec%0d_ready_at_boundary", i), duty_ready, 1);
      check_period($sformatf("vec%0d_period", i), r);
    end

    // transfer on the boundary cycle waits a full period
    repeat (PER - 1) tick();
    send(vecs[5].data);
    check("simul_ps", period_start, 1);
    check("simul_ready_low", duty_ready, 0);
    exp_q.push_back(vecs[4].exp_cnt);
    check_period("simul_old_period", r);
    check("simul_ready_low_60", r, 1);
    exp_q.push_back(vecs[5].exp_cnt);
    check_period("simul_new_period", r);

    // enable drop at phase 7, then restart at phase 0
    repeat (29) tick();
    check("phase7_led", led, 4'b0101);
    enable = 1'b0;
    tick();
    check("drop_led_off", led, 0);
    check("drop_ps", period_start, 0);
    repeat (3) tick();
    check("disabled_led_off", led, 0);
    enable = 1'b1;
    tick();
    check("restart_phase0_led", led, 4'b1111);
    wait_ps(n, r);
    check("restart_first_ps", n, PER - 1);
    exp_q.push_back(vecs[5].exp_cnt);
    check_period("restart_period", r);

    // reset with a pending update
    repeat (10) tick();
    send(16'hFFFF);
    check("pend_before_reset", duty_ready, 0);
    rst_n      = 1'b0;
    duty_valid = 1'b1;
    duty_data  = 16'hAAAA;
    tick();
    rst_n      = 1'b1;
    duty_valid = 1'b0;
    check("midreset_led", led, 0);
    check("midreset_ready", duty_ready, 1);
    check("midreset_ps", period_start, 0);
    d0 = duty_t'(vecs[2].data[3:0]);
    exp_q.push_back({4{4'd0, d0}});
    wait_ps(n, r);
    check("midreset_restart_ps", n, PER);
    check_period("midreset_period", r);
    check("midreset_ready_end", duty_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
